// File: rtl/ex_alu_pkg.sv
// Shared constants and types for the execute-stage ALU block.
package ex_alu_pkg;

  localparam int unsigned W_DEFAULT = 16;

  // ALUop encodings from the control unit
  localparam logic [1:0] ALUOP_MEM  = 2'b00;
  localparam logic [1:0] ALUOP_BR   = 2'b01;
  localparam logic [1:0] ALUOP_R    = 2'b10;
  localparam logic [1:0] ALUOP_PASS = 2'b11;

  // R-type funct encodings
  localparam logic [3:0] FUNCT_ADD = 4'b0000;
  localparam logic [3:0] FUNCT_SUB = 4'b0001;
  localparam logic [3:0] FUNCT_MUL = 4'b0100;
  localparam logic [3:0] FUNCT_DIV = 4'b0101;
  localparam logic [3:0] FUNCT_AND = 4'b1000;
  localparam logic [3:0] FUNCT_OR  = 4'b1001;
  localparam logic [3:0] FUNCT_SLL = 4'b1010;
  localparam logic [3:0] FUNCT_SRL = 4'b1011;
  localparam logic [3:0] FUNCT_ROL = 4'b1100;
  localparam logic [3:0] FUNCT_ROR = 4'b1101;

  // Decoded ALU operation
  typedef enum logic [3:0] {
    OP_ADD   = 4'b0000,
    OP_SUB   = 4'b0001,
    OP_AND   = 4'b0010,
    OP_OR    = 4'b0011,
    OP_MUL   = 4'b0100,
    OP_DIV   = 4'b0101,
    OP_SLL   = 4'b0110,
    OP_SRL   = 4'b0111,
    OP_ROL   = 4'b1000,
    OP_ROR   = 4'b1001,
    OP_PASSB = 4'b1010,
    OP_NOP   = 4'b1111
  } alu_op_e;

endpackage

// File: rtl/ex_alu_core.sv
// Purely combinational two's-complement ALU: result, high word/remainder, overflow.
module ex_alu_core
  import ex_alu_pkg::*;
#(
  parameter int unsigned W = W_DEFAULT
) (
  input  alu_op_e        operation,
  input  logic [W-1:0]   op1,
  input  logic [W-1:0]   op2,
  output logic [W-1:0]   result_c,
  output logic [W-1:0]   remainder_c,
  output logic           o_c
);

  localparam logic [W-1:0] MIN_NEG = {1'b1, {(W-1){1'b0}}};

  logic [W-1:0]   sum;
  logic [W-1:0]   diff;
  logic [2*W-1:0] prod;
  logic [2*W-1:0] dbl_l;
  logic [2*W-1:0] dbl_r;
  logic [3:0]     amt;

  // Shared arithmetic terms; the product is taken on sign-extended operands
  always_comb begin
    amt   = op2[3:0];
    sum   = op1 + op2;
    diff  = op1 - op2;
    prod  = {{W{op1[W-1]}}, op1} * {{W{op2[W-1]}}, op2};
    dbl_l = {op1, op1} << amt;
    dbl_r = {op1, op1} >> amt;
  end

  // Operation select with special-cased division corners
  always_comb begin
    result_c    = '0;
    remainder_c = '0;
    o_c         = 1'b0;
    case (operation)
      OP_ADD: begin
        result_c = sum;
        o_c      = (op1[W-1] == op2[W-1]) && (sum[W-1] != op1[W-1]);
      end
      OP_SUB: begin
        result_c = diff;
        o_c      = (op1[W-1] != op2[W-1]) && (diff[W-1] != op1[W-1]);
      end
      OP_AND:   result_c = op1 & op2;
      OP_OR:    result_c = op1 | op2;
      OP_MUL: begin
        result_c    = prod[W-1:0];
        remainder_c = prod[2*W-1:W];
      end
      OP_DIV: begin
        if (op2 == '0) begin
          remainder_c = op1;
          o_c         = 1'b1;
        end else if ((op1 == MIN_NEG) && (op2 == '1)) begin
          result_c = MIN_NEG;
          o_c      = 1'b1;
        end else begin
          result_c    = W'($signed(op1) / $signed(op2));
          remainder_c = W'($signed(op1) % $signed(op2));
        end
      end
      OP_SLL:   result_c = op1 << amt;
      OP_SRL:   result_c = op1 >> amt;
      OP_ROL:   result_c = dbl_l[2*W-1:W];
      OP_ROR:   result_c = dbl_r[W-1:0];
      OP_PASSB: result_c = op2;
      default:  result_c = '0;
    endcase
  end

endmodule

// File: rtl/ex_alu_unit.sv
// Execute-stage arithmetic: ALU-control decode, ALU and branch-target adder, one registered stage.
module ex_alu_unit
  import ex_alu_pkg::*;
#(
  parameter int unsigned W = W_DEFAULT
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         in_valid,
  input  logic [1:0]   alu_op,
  input  logic [3:0]   funct,
  input  logic [W-1:0] op1,
  input  logic [W-1:0] op2,
  input  logic [W-1:0] se_offset,
  input  logic [W-1:0] pc_in,
  output logic         out_valid,
  output logic [3:0]   operation,
  output logic [W-1:0] result,
  output logic [W-1:0] remainder,
  output logic         o,
  output logic [W-1:0] bl_result
);

  alu_op_e      dec_op_c;
  logic [W-1:0] result_c;
  logic [W-1:0] remainder_c;
  logic         o_c;
  logic [W-1:0] bl_c;

  // ALU-control decode from ALUop and funct
  always_comb begin
    dec_op_c = OP_NOP;
    case (alu_op)
      ALUOP_MEM:  dec_op_c = OP_ADD;
      ALUOP_BR:   dec_op_c = OP_SUB;
      ALUOP_PASS: dec_op_c = OP_PASSB;
      ALUOP_R: begin
        case (funct)
          FUNCT_ADD: dec_op_c = OP_ADD;
          FUNCT_SUB: dec_op_c = OP_SUB;
          FUNCT_MUL: dec_op_c = OP_MUL;
          FUNCT_DIV: dec_op_c = OP_DIV;
          FUNCT_AND: dec_op_c = OP_AND;
          FUNCT_OR:  dec_op_c = OP_OR;
          FUNCT_SLL: dec_op_c = OP_SLL;
          FUNCT_SRL: dec_op_c = OP_SRL;
          FUNCT_ROL: dec_op_c = OP_ROL;
          FUNCT_ROR: dec_op_c = OP_ROR;
          default:   dec_op_c = OP_NOP;
        endcase
      end
      default: dec_op_c = OP_NOP;
    endcase
  end

  // Branch target: offset is a halfword count, wraps modulo 2^W
  always_comb begin
    bl_c = W'(pc_in + (se_offset << 1));
  end

  ex_alu_core #(
    .W (W)
  ) u_core (
    .operation   (dec_op_c),
    .op1         (op1),
    .op2         (op2),
    .result_c    (result_c),
    .remainder_c (remainder_c),
    .o_c         (o_c)
  );

  // Output stage: valid tracks every cycle, data only loads on valid
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      out_valid <= 1'b0;
      operation <= 4'b0000;
      result    <= '0;
      remainder <= '0;
      o         <= 1'b0;
      bl_result <= '0;
    end else begin
      out_valid <= in_valid;
      if (in_valid) begin
        operation <= 4'(dec_op_c);
        result    <= result_c;
        remainder <= remainder_c;
        o         <= o_c;
        bl_result <= bl_c;
      end
    end
  end

endmodule

// File: tb/tb_ex_alu_unit.sv
// Directed self-checking bench for ex_alu_unit.
module tb_ex_alu_unit;

  logic        clk;
  logic        reset;
  logic        in_valid;
  logic [1:0]  alu_op;
  logic [3:0]  funct;
  logic [15:0] op1;
  logic [15:0] op2;
  logic [15:0] se_offset;
  logic [15:0] pc_in;
  logic        out_valid;
  logic [3:0]  operation;
  logic [15:0] result;
  logic [15:0] remainder;
  logic        o;
  logic [15:0] bl_result;

  int vec_cnt = 0;
  int err_cnt = 0;

  ex_alu_unit dut (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (in_valid),
    .alu_op    (alu_op),
    .funct     (funct),
    .op1       (op1),
    .op2       (op2),
    .se_offset (se_offset),
    .pc_in     (pc_in),
    .out_valid (out_valid),
    .operation (operation),
    .result    (result),
    .remainder (remainder),
    .o         (o),
    .bl_result (bl_result)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Drive one set of inputs, then sample 1 time unit after the capturing edge
  task automatic apply(input logic v, input logic [1:0] aop, input logic [3:0] fn,
                       input logic [15:0] a, input logic [15:0] b,
                       input logic [15:0] off, input logic [15:0] pc);
    in_valid = v; alu_op = aop; funct = fn; op1 = a; op2 = b;
    se_offset = off; pc_in = pc;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    reset = 1'b0;
    apply(1'b1, 2'b10, 4'b0000, 16'h1111, 16'h2222, 16'h0001, 16'h0100);
    vec_cnt++;
    if ({out_valid, operation, result, remainder, o, bl_result} !== 54'd0) begin
      err_cnt++; $display("FAIL reset_hold got %h want 0", {out_valid, operation, result, remainder, o, bl_result});
    end
    #2 reset = 1'b1;
    apply(1'b1, 2'b10, 4'b0000, 16'h1111, 16'h2222, 16'h0001, 16'h0100);
    vec_cnt++;
    if (out_valid !== 1'b1 || result !== 16'h3333 || bl_result !== 16'h0102) begin
      err_cnt++; $display("FAIL reset_release got v=%b r=%h bl=%h want v=1 r=3333 bl=0102", out_valid, result, bl_result);
    end
    // Mid-stream async reset, checked well before the next edge
    apply(1'b1, 2'b10, 4'b0001, 16'h0009, 16'h0002, 16'h0003, 16'h0200);
    #1 reset = 1'b0;
    #1;
    vec_cnt++;
    if ({out_valid, operation, result, remainder, o, bl_result} !== 54'd0) begin
      err_cnt++; $display("FAIL reset_async got %h want 0", {out_valid, operation, result, remainder, o, bl_result});
    end
    #1 reset = 1'b1;
    apply(1'b1, 2'b10, 4'b0001, 16'h0009, 16'h0002, 16'h0003, 16'h0200);
    vec_cnt++;
    if (out_valid !== 1'b1 || operation !== 4'b0001 || result !== 16'h0007 || bl_result !== 16'h0206) begin
      err_cnt++; $display("FAIL reset_recapture got v=%b op=%h r=%h bl=%h want 1 1 0007 0206", out_valid, operation, result, bl_result);
    end
  endtask

  task automatic test_add_sub;
    apply(1'b1, 2'b10, 4'b0000, 16'h7FFF, 16'h0001, 16'h0000, 16'h0000);
    vec_cnt++;
    if (result !== 16'h8000 || o !== 1'b1 || operation !== 4'b0000 || remainder !== 16'h0000) begin
      err_cnt++; $display("FAIL add_pos_ovf got r=%h o=%b op=%h rem=%h want 8000 1 0 0000", result, o, operation, remainder);
    end
    apply(1'b1, 2'b10, 4'b0001, 16'h0005, 16'h0007, 16'h0000, 16'h0000);
    vec_cnt++;
    if (result !== 16'hFFFE || o !== 1'b0 || operation !== 4'b0001) begin
      err_cnt++; $display("FAIL sub_neg got r=%h o=%b op=%h want FFFE 0 1", result, o, operation);
    end
    apply(1'b1, 2'b10, 4'b0000, 16'h8000, 16'hFFFF, 16'h0000, 16'h0000);
    vec_cnt++;
    if (result !== 16'h7FFF || o !== 1'b1) begin
      err_cnt++; $display("FAIL add_neg_ovf got r=%h o=%b want 7FFF 1", result, o);
    end
    apply(1'b1, 2'b10, 4'b0001, 16'h8000, 16'h0001, 16'h0000, 16'h0000);
    vec_cnt++;
    if (result !== 16'h7FFF || o !== 1'b1) begin
      err_cnt++; $display("FAIL sub_ovf got r=%h o=%b want 7FFF 1", result, o);
    end
  endtask

  task automatic test_mul_div;
    apply(1'b1, 2'b10, 4'b0100, 16'h0100, 16'h0200, 16'h0000, 16'h0000);
    vec_cnt++;
    if (result !== 16'h0000 || remainder !== 16'h0002 || o !== 1'b0 || operation !== 4'b0100) begin
      err_cnt++; $display("FAIL mul got r=%h rem=%h o=%b op=%h want 0000 0002 0 4", result, remainder, o, operation);
    end
    apply(1'b1, 2'b10, 4'b0100, 16'hFFFF, 16'h0003, 16'h0000, 16'h0000);
    vec_cnt++;
    if (result !== 16'hFFFD || remainder !== 16'hFFFF) begin
      err_cnt++; $display("FAIL mul_neg got r=%h rem=%h want FFFD FFFF", result, remainder);
    end
    apply(1'b1, 2'b10, 4'b0101, 16'hFFF9, 16'h0002, 16'h0000, 16'h0000);
    vec_cnt++;
    if (result !== 16'hFFFD || remainder !== 16'hFFFF || o !== 1'b0 || operation !== 4'b0101) begin
      err_cnt++; $display("FAIL div_neg got r=%h rem=%h o=%b op=%h want FFFD FFFF 0 5", result, remainder, o, operation);
    end
    apply(1'b1, 2'b10, 4'b0101, 16'h1234, 16'h0000, 16'h0000, 16'h0000);
    vec_cnt++;
    if (result !== 16'h0000 || remainder !== 16'h1234 || o !== 1'b1) begin
      err_cnt++; $display("FAIL div_zero got r=%h rem=%h o=%b want 0000 1234 1", result, remainder, o);
    end
    apply(1'b1, 2'b10, 4'b0101, 16'h8000, 16'hFFFF, 16'h0000, 16'h0000);
    vec_cnt++;
    if (result !== 16'h8000 || remainder !== 16'h0000 || o !== 1'b1) begin
      err_cnt++; $display("FAIL div_min got r=%h rem=%h o=%b want 8000 0000 1", result, remainder, o);
    end
  endtask

  task automatic test_logic_shift;
    apply(1'b1, 2'b10, 4'b1000, 16'hF0F0, 16'hFF00, 16'h0000, 16'h0000);
    vec_cnt++;
    if (result !== 16'hF000 || operation !== 4'b0010) begin
      err_cnt++; $display("FAIL and got r=%h op=%h want F000 2", result, operation);
    end
    apply(1'b1, 2'b10, 4'b1001, 16'hF0F0, 16'hFF00, 16'h0000, 16'h0000);
    vec_cnt++;
    if (result !== 16'hFFF0 || operation !== 4'b0011) begin
      err_cnt++; $display("FAIL or got r=%h op=%h want FFF0 3", result, operation);
    end
    apply(1'b1, 2'b10, 4'b1010, 16'h8001, 16'h0004, 16'h0000, 16'h0000);
    vec_cnt++;
    if (result !== 16'h0010 || operation !== 4'b0110) begin
      err_cnt++; $display("FAIL sll got r=%h op=%h want 0010 6", result, operation);
    end
    apply(1'b1, 2'b10, 4'b1011, 16'h8001, 16'h0004, 16'h0000, 16'h0000);
    vec_cnt++;
    if (result !== 16'h0800 || operation !== 4'b0111) begin
      err_cnt++; $display("FAIL srl got r=%h op=%h want 0800 7", result, operation);
    end
    apply(1'b1, 2'b10, 4'b1100, 16'h8001, 16'h0004, 16'h0000, 16'h0000);
    vec_cnt++;
    if (result !== 16'h0018 || operation !== 4'b1000) begin
      err_cnt++; $display("FAIL rol got r=%h op=%h want 0018 8", result, operation);
    end
    apply(1'b1, 2'b10, 4'b1101, 16'h8001, 16'h0004, 16'h0000, 16'h0000);
    vec_cnt++;
    if (result !== 16'h1800 || operation !== 4'b1001) begin
      err_cnt++; $display("FAIL ror got r=%h op=%h want 1800 9", result, operation);
    end
    // Amount field is op2[3:0]; 0x0010 gives zero shift
    apply(1'b1, 2'b10, 4'b1100, 16'h8001, 16'h0010, 16'h0000, 16'h0000);
    vec_cnt++;
    if (result !== 16'h8001) begin
      err_cnt++; $display("FAIL rol_zero got r=%h want 8001", result);
    end
  endtask

  task automatic test_decode;
    apply(1'b1, 2'b00, 4'b1111, 16'h0003, 16'h0004, 16'h0000, 16'h0000);
    vec_cnt++;
    if (operation !== 4'b0000 || result !== 16'h0007) begin
      err_cnt++; $display("FAIL dec_mem got op=%h r=%h want 0 0007", operation, result);
    end
    apply(1'b1, 2'b01, 4'b1111, 16'h0003, 16'h0004, 16'h0000, 16'h0000);
    vec_cnt++;
    if (operation !== 4'b0001 || result !== 16'hFFFF) begin
      err_cnt++; $display("FAIL dec_br got op=%h r=%h want 1 FFFF", operation, result);
    end
    apply(1'b1, 2'b11, 4'b0000, 16'h0003, 16'hABCD, 16'h0000, 16'h0000);
    vec_cnt++;
    if (operation !== 4'b1010 || result !== 16'hABCD) begin
      err_cnt++; $display("FAIL dec_pass got op=%h r=%h want A ABCD", operation, result);
    end
    apply(1'b1, 2'b10, 4'b0111, 16'h0003, 16'h0004, 16'h0000, 16'h0000);
    vec_cnt++;
    if (operation !== 4'b1111 || result !== 16'h0000 || remainder !== 16'h0000 || o !== 1'b0) begin
      err_cnt++; $display("FAIL dec_nop got op=%h r=%h rem=%h o=%b want F 0000 0000 0", operation, result, remainder, o);
    end
  endtask

  task automatic test_branch;
    apply(1'b1, 2'b01, 4'b0000, 16'h0000, 16'h0000, 16'hFFFC, 16'h0010);
    vec_cnt++;
    if (bl_result !== 16'h0008) begin
      err_cnt++; $display("FAIL bl_back got %h want 0008", bl_result);
    end
    apply(1'b1, 2'b01, 4'b0000, 16'h0000, 16'h0000, 16'h0002, 16'hFFFE);
    vec_cnt++;
    if (bl_result !== 16'h0002) begin
      err_cnt++; $display("FAIL bl_wrap got %h want 0002", bl_result);
    end
  endtask

  task automatic test_back_to_back;
    apply(1'b1, 2'b10, 4'b0000, 16'h0010, 16'h0020, 16'h0004, 16'h0100);
    vec_cnt++;
    if (out_valid !== 1'b1 || result !== 16'h0030 || bl_result !== 16'h0108) begin
      err_cnt++; $display("FAIL b2b_first got v=%b r=%h bl=%h want 1 0030 0108", out_valid, result, bl_result);
    end
    // Bubble: new inputs must be ignored, data held
    apply(1'b0, 2'b10, 4'b0100, 16'h7777, 16'h0003, 16'h0100, 16'h4000);
    vec_cnt++;
    if (out_valid !== 1'b0 || result !== 16'h0030 || operation !== 4'b0000 || bl_result !== 16'h0108 || remainder !== 16'h0000) begin
      err_cnt++; $display("FAIL bubble_hold got v=%b r=%h op=%h bl=%h rem=%h want 0 0030 0 0108 0000", out_valid, result, operation, bl_result, remainder);
    end
    apply(1'b1, 2'b10, 4'b0001, 16'h0010, 16'h0020, 16'h0001, 16'h0200);
    vec_cnt++;
    if (out_valid !== 1'b1 || result !== 16'hFFF0 || operation !== 4'b0001 || bl_result !== 16'h0202) begin
      err_cnt++; $display("FAIL b2b_after got v=%b r=%h op=%h bl=%h want 1 FFF0 1 0202", out_valid, result, operation, bl_result);
    end
    apply(1'b1, 2'b11, 4'b0000, 16'h0000, 16'h5A5A, 16'h0000, 16'h0000);
    vec_cnt++;
    if (out_valid !== 1'b1 || result !== 16'h5A5A || operation !== 4'b1010) begin
      err_cnt++; $display("FAIL b2b_next got v=%b r=%h op=%h want 1 5A5A A", out_valid, result, operation);
    end
  endtask

  initial begin
    in_valid = 1'b0; alu_op = 2'b00; funct = 4'b0000; op1 = '0; op2 = '0;
    se_offset = '0; pc_in = '0; reset = 1'b0;
    test_reset();
    test_add_sub();
    test_mul_div();
    test_logic_shift();
    test_decode();
    test_branch();
    test_back_to_back();
    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end

endmodule

// File: doc/ex_alu_unit.md
Name: ex_alu_unit

Overview:
Execute-stage arithmetic block of the 16-bit pipelined CPU. It combines three functions:
- ALU-control decode: ALUop plus funct field selects a 4-bit operation.
- 16-bit ALU: produces result, remainder (R15 data) and overflow.
- Branch-target adder: PC plus sign-extended offset shifted left by 1.
All outputs are registered once, so the block sits between the ID/EX buffer and the EX/M buffer with a fixed 1-cycle latency.

Parameters:
- W, 16, datapath width for operands, PC and results.

Ports:
- clk  in  1  rising-edge clock
- reset  in  1  asynchronous active-low reset
- in_valid  in  1  inputs are valid this cycle
- alu_op  in  2  ALUop from control (via ID/EX)
- funct  in  4  funct field of the R-type instruction
- op1  in  W  first operand (RD1)
- op2  in  W  second operand (RD2 or immediate, already muxed)
- se_offset  in  W  sign-extended branch offset (unshifted)
- pc_in  in  W  PC of the instruction in EX
- out_valid  out  1  registered in_valid
- operation  out  4  registered decoded operation
- result  out  W  registered ALU result, signed
- remainder  out  W  registered high product, remainder, or 0
- o  out  1  registered overflow / exception flag
- bl_result  out  W  registered branch target

Behaviour:
- Reset:
  - reset=0 asynchronously clears all outputs to 0; operation=0000.
  - Deassertion takes effect at the next clk edge.
- Latency: all combinational work completes within the cycle; outputs update on every rising clk edge when in_valid=1.
- When in_valid=0:
  - out_valid goes to 0.
  - Data outputs hold their previous values.
  - An in_valid=0 cycle between two valid cycles is a bubble; no state is carried over.
- Decode of alu_op:
  - 00 → ADD (load/store address).
  - 01 → SUB (branch compare).
  - 11 → PASSB.
  - 10 → use funct, mapped as follows:
    - 0000 ADD, 0001 SUB, 0100 MUL, 0101 DIV
    - 1000 AND, 1001 OR
    - 1010 SLL, 1011 SRL, 1100 ROL, 1101 ROR
    - any other funct → NOP
- Operation codes: ADD 0000, SUB 0001, AND 0010, OR 0011, MUL 0100, DIV 0101, SLL 0110, SRL 0111, ROL 1000, ROR 1001, PASSB 1010, NOP 1111.
- ALU rules (operands are two's complement):
  - ADD/SUB: result = op1 ± op2 modulo 2^16; o = signed overflow; remainder = 0.
  - MUL: 32-bit signed product; result = low 16 bits, remainder = high 16 bits, o = 0.
  - DIV: result = quotient truncated toward zero; remainder takes the sign of op1; o = 0.
  - DIV with op2 = 0: result = 0, remainder = op1, o = 1.
  - DIV with op1 = -32768 and op2 = -1: result = -32768, remainder = 0, o = 1.
  - AND/OR: bitwise; remainder = 0, o = 0.
  - Shifts and rotates use op2[3:0] as the amount. SRL is logical. An amount of 0 returns op1 unchanged.
  - PASSB: result = op2.
  - NOP: result = 0, remainder = 0, o = 0.
- bl_result = pc_in + (se_offset << 1), modulo 2^16. It is computed every valid cycle regardless of operation; overflow wraps silently.

Decomposition:
- Shared package ex_alu_pkg holds:
  - ALUop constants (ALUOP_MEM, ALUOP_BR, ALUOP_R, ALUOP_PASS)
  - funct constants
  - the operation enum/localparams listed above
  - W default
- Natural sub-module: ex_alu_core, the purely combinational ALU (operation, op1, op2 → result, remainder, o).
- ALU-control decode and the branch adder stay inline in the top.

Test Plan:
- Reset: hold reset=0 mid-stream with in_valid=1 → all outputs 0 immediately, without waiting for clk; first edge after release captures the new inputs.
- alu_op=10, funct=0000, op1=0x7FFF, op2=0x0001 → after 1 edge: result=0x8000, o=1, operation=0000. Then funct=0001, op1=0x0005, op2=0x0007 → result=0xFFFE, o=0.
- MUL with op1=0x0100, op2=0x0200 → result=0x0000, remainder=0x0002. DIV with op1=-7, op2=2 → result=0xFFFD, remainder=0xFFFF.
- DIV with op2=0 and op1=0x1234 → result=0, remainder=0x1234, o=1.
- Decode sweep: alu_op=00 → operation 0000; 01 → 0001; 11 → 1010 with result=op2; 10 with funct=0111 → NOP, result=0.
- Branch target: pc_in=0x0010, se_offset=0xFFFC → bl_result=0x0008. pc_in=0xFFFE, se_offset=0x0002 → bl_result=0x0002 (wrap). Also check that in_valid=0 holds outputs and clears out_valid.
